// File: rtl/mul_add_seq_if.sv
// Operand/result bundle for the mul_add_seq multiply-accumulate unit.
//
// Optional feature: define MUL_ADD_DIVCHK_EN to add the divider cross-check
// signals (dividend in, match out).
//
// Signals:
//   start    - operation request (master -> slave)
//   sign     - 1 = two's complement operands, 0 = unsigned
//   a, b, c  - multiplicand, multiplier, addend (WIDTH bits)
//   dividend - expected a*b+c for the cross-check (MUL_ADD_DIVCHK_EN only)
//   busy     - operation in flight (slave -> master)
//   done     - one-cycle completion pulse
//   prod     - a*b+c, 2*WIDTH bits
//   match    - cross-check result (MUL_ADD_DIVCHK_EN only)
interface mul_add_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic               sign;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;
`ifdef MUL_ADD_DIVCHK_EN
  logic [WIDTH-1:0]   dividend;
  logic               match;

  modport master (
    output start, sign, a, b, c, dividend,
    input  busy, done, prod, match
  );

  modport slave (
    input  start, sign, a, b, c, dividend,
    output busy, done, prod, match
  );
`else
  modport master (
    output start, sign, a, b, c,
    input  busy, done, prod
  );

  modport slave (
    input  start, sign, a, b, c,
    output busy, done, prod
  );
`endif
endinterface

// File: rtl/mul_add_seq.sv
// Sequential shift-add multiply-accumulate: prod = a*b + c in WIDTH+2 cycles.
// Feeding it (quotient, divisor, remainder) rebuilds the dividend, so it
// doubles as a cross-check for the divider.
//
// Optional feature: define MUL_ADD_DIVCHK_EN to compare the result against a
// supplied dividend and report match.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mul_add_seq_if.slave (start/sign/a/b/c in, busy/done/prod out)
module mul_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  mul_add_seq_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    cext_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    c_ext;
  logic [PW-1:0]    fix_sum;

  // Magnitudes are unsigned in WIDTH bits, so -2^(W-1) maps to 2^(W-1).
  always_comb begin
    a_mag   = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag   = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    c_ext   = bus.sign ? {{WIDTH{bus.c[WIDTH-1]}}, bus.c} : {{WIDTH{1'b0}}, bus.c};
    fix_sum = (neg_q ? -acc_q : acc_q) + cext_q;
  end

`ifdef MUL_ADD_DIVCHK_EN
  logic [PW-1:0]    dext_q;
  logic             chk_q;
  logic             match_q;
  logic [WIDTH-1:0] c_mag;
  logic [PW-1:0]    d_ext;
  logic             chk_pre;

  // Remainder bounds are operand-only, so they are resolved at start and
  // only the product comparison is left for FIX. b=0 fails |c|<|b| by itself.
  always_comb begin
    c_mag   = (bus.sign && bus.c[WIDTH-1]) ? -bus.c : bus.c;
    d_ext   = bus.sign ? {{WIDTH{bus.dividend[WIDTH-1]}}, bus.dividend}
                       : {{WIDTH{1'b0}}, bus.dividend};
    chk_pre = (c_mag < b_mag) &&
              (!bus.sign || (bus.c == '0) || (bus.c[WIDTH-1] == bus.dividend[WIDTH-1]));
  end

  assign bus.match = match_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cext_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUL_ADD_DIVCHK_EN
      dext_q   <= '0;
      chk_q    <= 1'b0;
      match_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cext_q   <= c_ext;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
`ifdef MUL_ADD_DIVCHK_EN
            dext_q   <= d_ext;
            chk_q    <= chk_pre;
`endif
          end
        end
        StRun: begin
          // Multiplier consumed LSB first; multiplicand pre-shifted to match.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CntLast) state_q <= StFix;
        end
        StFix: begin
          prod_q  <= fix_sum;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
`ifdef MUL_ADD_DIVCHK_EN
          match_q <= chk_q && (fix_sum == dext_q);
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_mul_add_seq.sv
`timescale 1ns/1ps
module tb_mul_add_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_add_seq_if #(.WIDTH(W)) bus ();

  mul_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] prod;
    logic        match;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int absv(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference: plain integer arithmetic on the interpreted operands.
  function automatic exp_t model(input bit s, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d);
    int   av, bv, cv, dv, r;
    exp_t e;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    cv = s ? int'($signed(c)) : int'(c);
    dv = s ? int'($signed(d)) : int'(d);
    r  = av * bv + cv;
    e.prod  = r[15:0];
    e.match = (r == dv) && (absv(cv) < absv(bv)) && (!s || cv == 0 || ((cv < 0) == (dv < 0)));
    return e;
  endfunction

  task automatic drive(input bit s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    bus.sign = s;
    bus.a    = a;
    bus.b    = b;
    bus.c    = c;
`ifdef MUL_ADD_DIVCHK_EN
    bus.dividend = d;
`endif
  endtask

  // Presents an operation and returns #1 after the accepting edge.
  task automatic launch(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input bit hold);
    @(negedge clk);
    drive(s, a, b, c, d);
    bus.start = 1'b1;
    sb.push_back(model(s, a, b, c, d));
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares; returns at the done sample.
  task automatic finish_op(input string tag, input bit chk_timing);
    int   lat;
    int   bcnt;
    exp_t e;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " done"}, 16'(bus.done), 16'(1));
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " prod"}, bus.prod, e.prod);
`ifdef MUL_ADD_DIVCHK_EN
      check({tag, " match"}, 16'(bus.match), 16'(e.match));
`endif
      if (chk_timing) begin
        check({tag, " latency"}, 16'(lat), 16'(W + 1));
        check({tag, " busy cycles"}, 16'(bcnt), 16'(W + 1));
      end
    end
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #12;
    check("reset busy", 16'(bus.busy), 16'(0));
    check("reset done", 16'(bus.done), 16'(0));
    check("reset prod", bus.prod, 16'h0000);
`ifdef MUL_ADD_DIVCHK_EN
    check("reset match", 16'(bus.match), 16'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned, with timing and single-cycle done.
    launch(1'b0, 8'd7, 8'd6, 8'd0, 8'd0, 1'b0);
    finish_op("u7x6", 1'b1);
    check("u7x6 value", bus.prod, 16'h002A);
    @(posedge clk);
    #1;
    check("done pulse width", 16'(bus.done), 16'(0));
    check("prod held", bus.prod, 16'h002A);

    // Signed rebuild and zero multiplicand.
    launch(1'b1, 8'hFA, 8'd7, 8'd0, 8'd0, 1'b0);
    finish_op("s-6x7", 1'b1);
    check("s-6x7 value", bus.prod, 16'hFFD6);
    launch(1'b1, 8'h00, 8'hD6, 8'd7, 8'd0, 1'b0);
    finish_op("s0x-42+7", 1'b1);

    // Extremes.
    launch(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    finish_op("u max", 1'b0);
    check("u max value", bus.prod, 16'hFF00);
    launch(1'b1, 8'h80, 8'h80, 8'h7F, 8'h00, 1'b0);
    finish_op("s min*min", 1'b0);
    check("s min*min value", bus.prod, 16'h407F);
    launch(1'b1, 8'h80, 8'h7F, 8'h80, 8'h00, 1'b0);
    finish_op("s min*max", 1'b0);
    check("s min*max value", bus.prod, 16'hC000);

    // Back-to-back with start held high.
    launch(1'b0, 8'd13, 8'd11, 8'd5, 8'd0, 1'b1);
    finish_op("b2b first", 1'b1);
    drive(1'b1, 8'hF3, 8'h09, 8'hFE, 8'h00);
    sb.push_back(model(1'b1, 8'hF3, 8'h09, 8'hFE, 8'h00));
    @(posedge clk);
    #1;
    check("b2b accepted", 16'(bus.busy), 16'(1));
    bus.start = 1'b0;
    finish_op("b2b second", 1'b0);

    // Start mid-RUN is ignored and not queued.
    launch(1'b0, 8'd9, 8'd10, 8'd3, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd200, 8'd200, 8'd200, 8'd0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_op("ignored start", 1'b0);
    check("ignored start value", bus.prod, 16'd93);
    repeat (2) @(posedge clk);
    #1;
    check("no queued op", 16'(bus.busy), 16'(0));

    // Reset mid-RUN aborts without a later done.
    launch(1'b1, 8'hF0, 8'h11, 8'h05, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 16'(bus.busy), 16'(0));
    check("abort done", 16'(bus.done), 16'(0));
    check("abort prod", bus.prod, 16'h0000);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    check("no done after abort", 16'(seen), 16'(0));
    launch(1'b0, 8'd100, 8'd3, 8'd1, 8'd0, 1'b0);
    finish_op("after reset", 1'b1);

`ifdef MUL_ADD_DIVCHK_EN
    launch(1'b1, 8'd3, 8'd37, 8'd16, 8'd127, 1'b0);
    finish_op("divchk ok", 1'b0);
    check("divchk ok match", 16'(bus.match), 16'(1));
    launch(1'b1, 8'd3, 8'd37, 8'd40, 8'd127, 1'b0);
    finish_op("divchk big rem", 1'b0);
    check("divchk big rem match", 16'(bus.match), 16'(0));
    launch(1'b1, 8'hFA, 8'd7, 8'd3, 8'hD9, 1'b0);
    finish_op("divchk rem sign", 1'b0);
    check("divchk rem sign match", 16'(bus.match), 16'(0));
`endif

    check("scoreboard drained", 16'(sb.size()), 16'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
